// File: rtl/ttl_bus_capture_fifo.sv
// ttl_bus_capture_fifo: captures the shared tri-state bus into a show-ahead
// FIFO when strobed while driven; sticky flags report undriven/full captures.
module ttl_bus_capture_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int DELAY_RISE = 8,
    parameter int DELAY_FALL = 8
) (
    input  logic                   Clk,
    input  logic                   Reset_bar,
    input  logic                   OE1_bar,
    input  logic                   OE2_bar,
    input  logic [WIDTH-1:0]       Bus,
    input  logic                   Load_bar,
    input  logic                   Ready,
    input  logic                   Clr_err_bar,
    output logic [WIDTH-1:0]       Q,
    output logic                   Valid,
    output logic                   Full,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overrun,
    output logic                   Float_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Delays annotate clock-to-output timing for board models only.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
        $error("ttl_bus_capture_fifo: illegal parameters");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             float_q, float_d;
    logic             driven, push_req, pop, push_ok;
    logic             full, valid;

    assign full  = (count_q == CW'(DEPTH));
    assign valid = (count_q != '0);

    always_comb begin
        driven    = !OE1_bar && !OE2_bar;
        push_req  = !Load_bar && driven;
        pop       = valid && Ready;
        // A same-cycle pop frees the slot a full FIFO needs.
        push_ok   = push_req && (!full || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push_ok) - CW'(pop);
        overrun_d = Clr_err_bar ? overrun_q : 1'b0;
        float_d   = Clr_err_bar ? float_q : 1'b0;
        if (push_req && full && !pop) begin
            overrun_d = 1'b1;
        end
        if (!Load_bar && !driven) begin
            float_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_bar) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            float_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            float_q   <= float_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (Reset_bar && push_ok) begin
            mem_q[wr_ptr_q] <= Bus;
        end
    end

    assign Q         = valid ? mem_q[rd_ptr_q] : '0;
    assign Valid     = valid;
    assign Full      = full;
    assign Count     = count_q;
    assign Overrun   = overrun_q;
    assign Float_err = float_q;

endmodule

// File: doc/ttl_bus_capture_fifo.md
# ttl_bus_capture_fifo

Receiving end of the shared tri-state data bus driven by the octal buffer stages. On each rising clock edge where a load strobe is asserted and the bus driver's output enables show the bus is actively driven, it captures the bus value into a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake. Protocol misuse (capture while the bus is undriven, capture while full) raises sticky error flags.

## Interface
- WIDTH, 8, bus and data width in bits
- DEPTH, 4, FIFO entries; power of two, 2..16
- DELAY_RISE, 8, clock-to-output rise delay (ns) on all outputs
- DELAY_FALL, 8, clock-to-output fall delay (ns) on all outputs

Ports:
- Clk  input  1  system clock; all state changes on the rising edge
- Reset_bar  input  1  synchronous, active-low reset, sampled on the rising edge of Clk
- OE1_bar  input  1  bus driver enable 1, monitored (low = driving)
- OE2_bar  input  1  bus driver enable 2, monitored (low = driving)
- Bus  input  WIDTH  shared tri-state data bus
- Load_bar  input  1  capture strobe, active low
- Ready  input  1  consumer accepts the head entry this cycle
- Clr_err_bar  input  1  active-low synchronous clear of the sticky error flags
- Q  output  WIDTH  head-of-FIFO data; all zeros when empty
- Valid  output  1  FIFO non-empty
- Full  output  1  FIFO holds DEPTH entries
- Count  output  $clog2(DEPTH)+1  number of stored entries
- Overrun  output  1  sticky: capture dropped because FIFO full
- Float_err  output  1  sticky: capture requested while bus undriven

## Operation
- Driven = (OE1_bar==0) && (OE2_bar==0).
- Push request = (Load_bar==0) && Driven. Pop = Valid && Ready.
- Push accepted if not Full, or if Full and Pop occurs in the same cycle (the pop frees the slot). An accepted push writes Bus to mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop increments rd_ptr modulo DEPTH. Pop while empty is ignored; Ready with Valid=0 has no effect.
- Count next = Count + push_accepted − pop. It never exceeds DEPTH or goes below 0.
- Full = (Count==DEPTH). Valid = (Count!=0). Q = mem[rd_ptr] when Valid, else 0. This is a show-ahead FIFO: the head is visible without a pop.
- Overrun sets when a push request is rejected (Full and no Pop).
- Float_err sets when Load_bar==0 and not Driven. No write occurs in that case.
- Both flags stay set until Clr_err_bar==0 at an edge, or reset. If a clear and a set event occur in the same cycle, set wins.
- Storage contents are not reset. Only pointers, Count and flags are reset.

## Timing
- Reset (Reset_bar==0 at an edge) forces wr_ptr=rd_ptr=0, Count=0, Overrun=0, Float_err=0. Outputs then read Q=0, Valid=0, Full=0.
- Reset has priority over push, pop and clear. A capture in a reset cycle is discarded, including mid-burst.
- Capture latency: Bus sampled at edge N appears on Q, with Valid=1, DELAY_RISE/FALL after edge N if the FIFO was empty.
- Pop latency: a pop at edge N presents the next entry, or Q=0 and Valid=0, after edge N.
- Flags update at the same edge as the triggering event.
- Pointer wrap: entry DEPTH+1 is written to slot 0 once slot 0 has been popped; ordering is preserved across the wrap.
- Bus must be stable for setup/hold around the edge. X or Z on Bus while Driven is captured as is; it is not flagged.
- Bench clock period is ≥ 50 ns; sample outputs ≥ 10 ns after the edge.

## Test plan
- Reset then idle: after 2 cycles with Reset_bar=0, expect Q=0, Valid=0, Full=0, Count=0, Overrun=0, Float_err=0.
- Fill and drain, DEPTH=4: push 0x11,0x22,0x33,0x44 with Ready=0 → Count=4, Full=1, Q=0x11. Then hold Ready=1 for 4 cycles → Q sequence 0x22,0x33,0x44,0x00; Valid drops after the 4th pop.
- Overrun and full-with-pop: with the FIFO full, push 0x55 with Ready=0 → Overrun=1 and Count stays 4. Next, push 0x66 with Ready=1 → accepted, Count stays 4, and 0x66 is the last entry read out.
- Float error: Load_bar=0 with OE1_bar=1 and Bus=0xAA → Float_err=1, Count unchanged. Then Clr_err_bar=0 for one edge → Float_err=0.
- Wrap-around: 10 interleaved push/pop pairs of values 0x01..0x0A → Q outputs in order 0x01..0x0A, Count ≤ 1 throughout.
- Reset mid-operation: with Count=3, assert Reset_bar=0 together with a valid push of 0x77 → Count=0, Valid=0, and 0x77 never appears on Q.
